fixed_point_vector_alu: RTL and testbench

- Multi-lane sequential fixed-point ALU, successor to the package's combinational fixed-point helpers.
- Parametrised in integer bits, fractional bits and lane count.
- Operands and results use valid/ready handshakes.
- MUL has selectable rounding; DIV is exact and multi-cycle; every lane reports saturation and divide-by-zero.
- Sits between the vector register file and the ternary matmul datapath, serving the normalisation and scaling steps.

---
 rtl/fixed_point_vector_alu_pkg.sv | 53 +++++
 rtl/fixed_point_vector_alu_div_lane.sv | 121 ++++++++++++
 rtl/fixed_point_vector_alu.sv | 176 +++++++++++++++++
 tb/tb_fixed_point_vector_alu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_vector_alu_pkg.sv
// Shared types and helpers for the multi-lane fixed-point ALU.
// Default geometry is Q5.3 over four lanes.
package fixed_point_vector_alu_pkg;

    localparam int DEF_INT_BITS  = 5;
    localparam int DEF_FRAC_BITS = 3;
    localparam int DEF_LANES     = 4;
    localparam int DEF_W         = DEF_INT_BITS + DEF_FRAC_BITS;

    localparam logic signed [DEF_W-1:0] DEF_MAXV = {1'b0, {(DEF_W-1){1'b1}}};
    localparam logic signed [DEF_W-1:0] DEF_MINV = {1'b1, {(DEF_W-1){1'b0}}};

    typedef logic signed [DEF_W-1:0]         fixed_point_t;
    typedef logic [DEF_LANES*DEF_W-1:0]      vector_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_DIV = 3'd3,
        OP_MUL = 3'd4,
        OP_EXP = 3'd5
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    // Clamp a wide signed value into the range of a w-bit two's complement word.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int w,
                                                    output logic sat);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] r;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            r   = lo;
            sat = 1'b1;
        end else begin
            r   = v;
            sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_vector_alu_div_lane.sv
// One lane of the iterative restoring divider: one quotient bit per clock,
// result signed and clamped, divide-by-zero reported separately.
module fixed_point_vector_alu_div_lane
    import fixed_point_vector_alu_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] q_o,
    output logic         sat_o,
    output logic         div_zero_o
);

    localparam int Q  = W + FRAC_BITS + 1;
    localparam int CW = $clog2(Q + 1);

    logic [Q-1:0]  num_r;
    logic [Q-1:0]  quo_r;
    logic [W:0]    rem_r;
    logic [W:0]    den_r;
    logic [CW-1:0] cnt_r;
    logic          run_r;
    logic          neg_r;
    logic          a_neg_r;
    logic          dz_r;

    logic [W:0]         a_mag_s;
    logic [W:0]         b_mag_s;
    logic [W+1:0]       rem_sh_s;
    logic [W:0]         rem_nx_s;
    logic               bit_s;
    logic signed [31:0] quo_x_s;
    logic signed [31:0] q_val_s;
    logic               q_sat_s;

    // Operand magnitudes at W+1 bits so that |MINV| is representable.
    always_comb begin
        if (a_i[W-1]) begin
            a_mag_s = {1'b0, ~a_i} + {{W{1'b0}}, 1'b1};
        end else begin
            a_mag_s = {1'b0, a_i};
        end
        if (b_i[W-1]) begin
            b_mag_s = {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
        end else begin
            b_mag_s = {1'b0, b_i};
        end
    end

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_r, num_r[Q-1]};
        bit_s    = (rem_sh_s >= {1'b0, den_r});
        if (bit_s) begin
            rem_nx_s = (W+1)'(rem_sh_s - {1'b0, den_r});
        end else begin
            rem_nx_s = rem_sh_s[W:0];
        end
    end

    // Divider state: load on start, then Q iterations, then idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_r   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            den_r   <= '0;
            cnt_r   <= '0;
            run_r   <= 1'b0;
            neg_r   <= 1'b0;
            a_neg_r <= 1'b0;
            dz_r    <= 1'b0;
        end else if (start_i) begin
            num_r   <= {a_mag_s, {FRAC_BITS{1'b0}}};
            quo_r   <= '0;
            rem_r   <= '0;
            den_r   <= b_mag_s;
            cnt_r   <= CW'(Q);
            run_r   <= 1'b1;
            neg_r   <= a_i[W-1] ^ b_i[W-1];
            a_neg_r <= a_i[W-1];
            dz_r    <= (b_i == {W{1'b0}});
        end else if (run_r) begin
            if (cnt_r != {CW{1'b0}}) begin
                num_r <= {num_r[Q-2:0], 1'b0};
                rem_r <= rem_nx_s;
                quo_r <= {quo_r[Q-2:0], bit_s};
                cnt_r <= cnt_r - CW'(1);
            end else begin
                run_r <= 1'b0;
            end
        end else begin
            run_r <= 1'b0;
        end
    end

    assign done_o = run_r && (cnt_r == {CW{1'b0}});

    // Apply the quotient sign and clamp; division by zero pins to the rail of a's sign.
    always_comb begin
        quo_x_s = $signed({{(32-Q){1'b0}}, quo_r});
        q_val_s = neg_r ? -quo_x_s : quo_x_s;
        q_sat_s = 1'b0;
        if (dz_r) begin
            q_o        = a_neg_r ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            sat_o      = 1'b0;
            div_zero_o = 1'b1;
        end else begin
            q_o        = W'(saturate(q_val_s, W, q_sat_s));
            sat_o      = q_sat_s;
            div_zero_o = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_point_vector_alu.sv
// Multi-lane sequential fixed-point ALU with valid/ready on both sides;
// single-cycle ADD/SUB/MUL/NOP and a per-lane multi-cycle exact divider.
module fixed_point_vector_alu
    import fixed_point_vector_alu_pkg::*;
#(
    parameter int IntBits  = DEF_INT_BITS,
    parameter int FracBits = DEF_FRAC_BITS,
    parameter int Lanes    = DEF_LANES
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         op_i,
    input  logic               round_i,
    input  logic [Lanes*(IntBits+FracBits)-1:0] a_i,
    input  logic [Lanes*(IntBits+FracBits)-1:0] b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [Lanes*(IntBits+FracBits)-1:0] result_o,
    output logic [Lanes-1:0]   sat_o,
    output logic [Lanes-1:0]   div_zero_o,
    output logic               op_err_o
);

    localparam int W = IntBits + FracBits;
    localparam logic signed [31:0] HALF = 32'sd1 <<< (FracBits - 1);

    state_t                 state_r;
    state_t                 next_s;
    operation_t             op_s;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [Lanes*W-1:0]     result_r;
    logic [Lanes-1:0]       sat_r;
    logic [Lanes-1:0]       dz_r;
    logic                   err_r;

    logic                   is_div_s;
    logic                   accept_s;
    logic                   start_s;
    logic [Lanes*W-1:0]     alu_res_s;
    logic [Lanes-1:0]       alu_sat_s;
    logic                   alu_err_s;
    logic signed [31:0]     ax_s;
    logic signed [31:0]     bx_s;
    logic signed [31:0]     pre_s;
    logic                   lane_sat_s;

    logic [Lanes-1:0]       div_done_v_s;
    logic                   div_done_s;
    logic [Lanes*W-1:0]     div_q_s;
    logic [Lanes-1:0]       div_sat_s;
    logic [Lanes-1:0]       div_dz_s;

    assign op_s       = operation_t'(op_i);
    assign is_div_s   = (op_s == OP_DIV);
    assign accept_s   = in_ready_r && in_valid_i;
    assign start_s    = accept_s && is_div_s;
    assign div_done_s = &div_done_v_s;

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        fixed_point_vector_alu_div_lane #(
            .W         (W),
            .FRAC_BITS (FracBits)
        ) u_div (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .start_i    (start_s),
            .a_i        (a_i[g*W +: W]),
            .b_i        (b_i[g*W +: W]),
            .done_o     (div_done_v_s[g]),
            .q_o        (div_q_s[g*W +: W]),
            .sat_o      (div_sat_s[g]),
            .div_zero_o (div_dz_s[g])
        );
    end

    // Single-cycle lane arithmetic; widened to 32 bits so nothing wraps before the clamp.
    always_comb begin
        alu_res_s  = '0;
        alu_sat_s  = '0;
        alu_err_s  = 1'b0;
        ax_s       = '0;
        bx_s       = '0;
        pre_s      = '0;
        lane_sat_s = 1'b0;
        case (op_s)
            OP_NOP: alu_res_s = a_i;
            OP_ADD, OP_SUB, OP_MUL: begin
                for (int i = 0; i < Lanes; i++) begin
                    ax_s = 32'(signed'(a_i[i*W +: W]));
                    bx_s = 32'(signed'(b_i[i*W +: W]));
                    if (op_s == OP_ADD) begin
                        pre_s = ax_s + bx_s;
                    end else if (op_s == OP_SUB) begin
                        pre_s = ax_s - bx_s;
                    end else begin
                        pre_s = (ax_s * bx_s + (round_i ? HALF : 32'sd0)) >>> FracBits;
                    end
                    alu_res_s[i*W +: W] = W'(saturate(pre_s, W, lane_sat_s));
                    alu_sat_s[i]        = lane_sat_s;
                end
            end
            OP_DIV: alu_err_s = 1'b0;
            default: alu_err_s = 1'b1;
        endcase
    end

    // Next-state logic for the request/hold sequencing.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    next_s = is_div_s ? ST_DIV_BUSY : ST_HOLD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_DIV_BUSY: begin
                if (div_done_s) begin
                    next_s = ST_HOLD;
                end else begin
                    next_s = ST_DIV_BUSY;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_HOLD;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // State register plus registered handshake outputs and result capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            sat_r       <= '0;
            dz_r        <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= next_s;
            in_ready_r  <= (next_s == ST_IDLE);
            out_valid_r <= (next_s == ST_HOLD);
            if (accept_s && !is_div_s) begin
                result_r <= alu_res_s;
                sat_r    <= alu_sat_s;
                dz_r     <= '0;
                err_r    <= alu_err_s;
            end else if ((state_r == ST_DIV_BUSY) && div_done_s) begin
                result_r <= div_q_s;
                sat_r    <= div_sat_s;
                dz_r     <= div_dz_s;
                err_r    <= 1'b0;
            end else begin
                err_r    <= err_r;
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;
    assign sat_o       = sat_r;
    assign div_zero_o  = dz_r;
    assign op_err_o    = err_r;

endmodule

// File: tb/tb_fixed_point_vector_alu.sv
// Directed scoreboard bench for fixed_point_vector_alu at Q5.3 x 4 lanes.
module tb_fixed_point_vector_alu;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int VW = W * L;

    typedef struct {
        string         tag;
        logic [VW-1:0] res;
        logic [L-1:0]  sat;
        logic [L-1:0]  dz;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic          rnd;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;
    logic [L-1:0]  sat;
    logic [L-1:0]  div_zero;
    logic          op_err;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    fixed_point_vector_alu #(.IntBits(5), .FracBits(3), .Lanes(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .round_i     (rnd),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .sat_o       (sat),
        .div_zero_o  (div_zero),
        .op_err_o    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [VW-1:0] res, input logic [L-1:0] s,
                        input logic [L-1:0] dz, input logic err);
        exp_t x;
        x.tag = tag; x.res = res; x.sat = s; x.dz = dz; x.err = err;
        sb.push_back(x);
    endtask

    // Present a request and return 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic r, input logic [VW-1:0] av,
                         input logic [VW-1:0] bv);
        int n;
        @(negedge clk);
        op = o; rnd = r; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result, compare it against the scoreboard head, then complete the handshake.
    task automatic collect(input int exp_lat);
        int   lat;
        logic ready_low;
        exp_t x;
        lat = 0;
        ready_low = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        x = sb.pop_front();
        chk({x.tag, "_valid"},   {31'd0, out_valid}, 32'd1);
        chk({x.tag, "_latency"}, lat, exp_lat);
        chk({x.tag, "_busy"},    {31'd0, ready_low & ~in_ready}, 32'd1);
        chk({x.tag, "_result"},  result, x.res);
        chk({x.tag, "_sat"},     {28'd0, sat}, {28'd0, x.sat});
        chk({x.tag, "_dz"},      {28'd0, div_zero}, {28'd0, x.dz});
        chk({x.tag, "_err"},     {31'd0, op_err}, {31'd0, x.err});
        @(posedge clk);
        #1;
        chk({x.tag, "_retire"},  {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rnd = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags",  {22'd0, sat, div_zero, 1'b0, op_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        push("add", 32'h00_80_10_7F, 4'b0101, 4'b0000, 1'b0);
        issue(3'd1, 1'b0, 32'h10_80_08_70, 32'hF0_F0_08_20);
        collect(0);

        push("sub", 32'hF0_08_7F_80, 4'b0011, 4'b0000, 1'b0);
        issue(3'd2, 1'b0, 32'h00_10_7F_80, 32'h10_08_FF_01);
        collect(0);

        push("mul_trunc", 32'h20_7F_FB_04, 4'b0100, 4'b0000, 1'b0);
        issue(3'd4, 1'b0, 32'h10_7F_FA_06, 32'h10_7F_06_06);
        collect(0);

        push("mul_round", 32'h20_7F_FC_05, 4'b0100, 4'b0000, 1'b0);
        issue(3'd4, 1'b1, 32'h10_7F_FA_06, 32'h10_7F_06_06);
        collect(0);

        push("nop", 32'hDE_AD_BE_EF, 4'b0000, 4'b0000, 1'b0);
        issue(3'd0, 1'b1, 32'hDE_AD_BE_EF, 32'h12_34_56_78);
        collect(0);

        push("reserved", 32'h00_00_00_00, 4'b0000, 4'b0000, 1'b1);
        issue(3'd6, 1'b0, 32'h11_22_33_44, 32'h55_66_77_88);
        collect(0);

        push("div_zero", 32'h80_7F_F4_0C, 4'b0000, 4'b1100, 1'b0);
        issue(3'd3, 1'b0, 32'hF8_08_E8_18, 32'h00_00_10_10);
        collect(13);

        push("div_sat", 32'hFE_08_7F_80, 4'b0011, 4'b0000, 1'b0);
        issue(3'd3, 1'b0, 32'hFF_7F_80_80, 32'h03_7F_FC_04);
        collect(13);

        // Reset in the middle of a division: nothing from it may ever emerge.
        issue(3'd3, 1'b0, 32'h18_18_18_18, 32'h10_10_10_10);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("middiv_valid",  {31'd0, out_valid}, 32'd0);
        chk("middiv_result", result, 32'd0);
        chk("middiv_flags",  {22'd0, sat, div_zero, 1'b0, op_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("middiv_stale", seen, 32'd0);

        push("add_after_rst", 32'h02_03_04_05, 4'b0000, 4'b0000, 1'b0);
        issue(3'd1, 1'b0, 32'h01_02_03_04, 32'h01_01_01_01);
        collect(0);

        // Backpressure: the result must hold while a second request waits.
        out_ready = 1'b0;
        push("bp_add", 32'h10_10_10_10, 4'b0000, 4'b0000, 1'b0);
        issue(3'd1, 1'b0, 32'h08_08_08_08, 32'h08_08_08_08);
        e = sb.pop_front();
        @(negedge clk);
        op = 3'd5; rnd = 1'b0; a = 32'h7F_7F_7F_7F; b = 32'h01_01_01_01; in_valid = 1'b1;
        push("exp", 32'h00_00_00_00, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",  {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, e.res);
            chk("bp_flags",  {24'd0, sat, div_zero}, {24'd0, e.sat, e.dz});
            chk("bp_ready",  {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
